// File: rtl/ha_result_fifo_if.sv
// Handshake bundle between the half-adder stage, the result FIFO and its consumer.
// The slave modport is the FIFO's view. The master modport is the surrounding environment's view.
interface ha_result_fifo_if;
  logic in_valid;
  logic in_sum;
  logic in_carry;
  logic in_ready;
  logic out_valid;
  logic out_sum;
  logic out_carry;
  logic out_ready;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/ha_result_fifo.sv
// Buffers half-adder {carry,sum} results for a slower consumer.
// Also keeps a saturating carry count and a sticky overflow flag.
module ha_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ha_result_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         carry_count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic carry;
    logic sum;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;
  entry_t           head;

  // Full and empty flags come straight from the registered occupancy. There is no bypass or push-through.
  always_comb begin
    bus.in_ready  = (level != LVL_W'(DEPTH));
    bus.out_valid = (level != LVL_W'(0));
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
    head          = mem[rptr];
    bus.out_sum   = head.sum;
    bus.out_carry = head.carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem         <= '{default: '0};
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      carry_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= '{carry: bus.in_carry, sum: bus.in_sum};
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // The count holds at all-ones instead of wrapping.
      if (push && bus.in_carry && (carry_count != {CNT_W{1'b1}})) begin
        carry_count <= carry_count + CNT_W'(1);
      end
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ha_result_fifo.sv
// Scoreboard bench for ha_result_fifo: directed scenarios followed by random traffic.
// Results are compared against a queue-based reference model.
module tb_ha_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       level;
  logic [CNT_W-1:0] carry_count;
  logic             overflow;

  ha_result_fifo_if bus ();

  ha_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .level       (level),
    .carry_count (carry_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected queue contents as {carry,sum} plus the flags.
  logic [1:0] exp_q[$];
  int         m_level = 0;
  int         m_cnt   = 0;
  bit         m_ov    = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model update at each edge. The pushed data is whatever the half adder offered.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_level = 0;
      m_cnt   = 0;
      m_ov    = 1'b0;
    end else begin
      bit full;
      bit do_push;
      bit do_pop;
      full    = (m_level == DEPTH);
      do_push = bus.in_valid && !full;
      do_pop  = bus.out_ready && (m_level != 0);
      if (bus.in_valid && full) m_ov = 1'b1;
      if (do_push) begin
        exp_q.push_back({bus.in_carry, bus.in_sum});
        if (bus.in_carry && m_cnt < CMAX) m_cnt++;
      end
      m_level = m_level + int'(do_push) - int'(do_pop);
    end
  end

  // Monitor: checks the status outputs every cycle. When a transfer is presented, it pops the expected head and compares the data.
  always @(negedge clk) begin
    check("level", int'(level), m_level);
    check("out_valid", int'(bus.out_valid), int'(m_level != 0));
    check("in_ready", int'(bus.in_ready), int'(m_level != DEPTH));
    check("carry_count", int'(carry_count), m_cnt);
    check("overflow", int'(overflow), int'(m_ov));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_sum", int'(bus.out_sum), int'(exp_q[0][0]));
        check("out_carry", int'(bus.out_carry), int'(exp_q[0][1]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit a, input bit b, input bit ordy, input bit r);
    bus.in_valid  = v;
    bus.in_sum    = a ^ b;
    bus.in_carry  = a & b;
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    bus.in_valid  = 1'b1;
    bus.in_sum    = 1'b0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Hold reset while upstream is valid.
    drive(1, 1, 1, 0, 1);
    drive(1, 1, 1, 0, 1);
    check("rst_level", int'(level), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_carry_count", int'(carry_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_data", int'({bus.out_carry, bus.out_sum}), 0);

    // Single transfer of carry=1, sum=0.
    drive(1, 1, 1, 0, 0);
    check("single_out_valid", int'(bus.out_valid), 1);
    check("single_out_carry", int'(bus.out_carry), 1);
    check("single_out_sum", int'(bus.out_sum), 0);
    check("single_level", int'(level), 1);
    check("single_count", int'(carry_count), 1);
    drive(0, 0, 0, 1, 0);
    check("single_pop_level", int'(level), 0);
    check("single_pop_valid", int'(bus.out_valid), 0);

    // Fill with all four half-adder input combinations, then offer one more at full while popping.
    for (int ab = 0; ab < 4; ab++) drive(1, ab[1], ab[0], 0, 0);
    check("fill_level", int'(level), 4);
    check("fill_in_ready", int'(bus.in_ready), 0);
    drive(1, 1, 1, 1, 0);
    check("full_pop_level", int'(level), 3);
    check("full_overflow", int'(overflow), 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    check("fill_count", int'(carry_count), 2);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
    check("overflow_sticky", int'(overflow), 1);

    // Simultaneous push and pop at level 2 across pointer wrap.
    drive(0, 0, 0, 0, 1);
    check("rst_clears_overflow", int'(overflow), 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'($urandom), 1'($urandom), 1, 0);
      check("steady_level", int'(level), 2);
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    // Saturating carry count, then reset while entries are buffered.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1, 0);
      check("sat_count", int'(carry_count), sat_exp[i]);
    end
    drive(1, 1, 1, 0, 0);
    check("sat_level", int'(level), 2);
    drive(1, 1, 1, 1, 1);
    check("midrst_level", int'(level), 0);
    check("midrst_count", int'(carry_count), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 99) < 50), ($urandom_range(0, 299) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 0, 1, 0);
    check("drain_level", int'(level), 0);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ha_result_fifo.md
# ha_result_fifo

Buffers the sum/carry result pairs produced by the half-adder stage and hands them downstream over a valid/ready handshake, decoupling the adder from a slower consumer (UART/LED display logic on the tile). Holds up to DEPTH entries and keeps a saturating count of carry-out events. It also raises a sticky flag if the adder presents a result while the buffer is full. It sits directly downstream of the half adder, on the tile's single clock domain.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, 8, width of carry_count
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  one clock; reset is synchronous and active-high
- in_valid  input  1  upstream presents a result pair this cycle
- in_sum  input  1  half-adder sum bit (a ^ b)
- in_carry  input  1  half-adder carry bit (a & b)
- in_ready  output  1  buffer can accept; equals !full
- out_valid  output  1  head entry available; equals !empty
- out_sum  output  1  sum bit of head entry
- out_carry  output  1  carry bit of head entry
- out_ready  input  1  downstream accepts head this cycle
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- carry_count  output  CNT_W  saturating count of accepted entries with carry=1
- overflow  output  1  sticky: a result was offered while full

## Operation
- Storage: DEPTH x 2-bit array {carry,sum}, write pointer, read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter level.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- push: write {in_carry,in_sum} at wptr, wptr+1.
- pop: rptr+1.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.
- in_ready = (level != DEPTH); out_valid = (level != 0). Both are purely combinational from registered level.
- out_sum/out_carry = array[rptr], combinational read. Value is don't-care when out_valid=0, but it must not be X after reset: the array resets to 0.
- Full: in_ready=0 even if out_ready=1 that cycle; no push-through at full.
- Empty: no bypass. A push into an empty buffer appears at the output the next cycle.
- carry_count: +1 on each push with in_carry=1. It holds at 2^CNT_W−1 (no wrap).
- overflow: set when in_valid=1 and in_ready=0; cleared only by rst. The rejected data is dropped by the upstream stage's own semantics; the FIFO never writes it.
- rst: clears pointers, level, array, carry_count and overflow in the same edge. It overrides any concurrent push/pop.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_carry=0, level=0, carry_count=0, overflow=0.
- Latency: push at edge N gives out_valid=1 and data valid after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH.
- Handshake: data transfers only on the edge where valid & ready are both high. Upstream may drop in_valid at any time. out_* hold stable while out_valid=1 and out_ready=0.
- rst asserted mid-stream: the next cycle shows reset values; all buffered entries are lost.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> after release level=0, out_valid=0, in_ready=1, carry_count=0, overflow=0.
- Single transfer: push {carry=1,sum=0} with out_ready=0 -> next cycle out_valid=1, out_carry=1, out_sum=0, level=1, carry_count=1. Then out_ready=1 for one cycle -> level=0, out_valid=0.
- Fill/order (DEPTH=4): push the half-adder outputs for ab=00,01,10,11 -> level=4, in_ready=0. Pop all -> sum,carry sequence (0,0),(1,0),(1,0),(0,1); carry_count=1.
- Full + overflow: at level=4 drive in_valid=1, out_ready=1 -> no push, one pop, level=3, overflow=1. overflow stays 1 through 10 more cycles until rst.
- Simultaneous push/pop at level=2 for 8 cycles -> level stays 2, FIFO order preserved across pointer wrap.
- Saturation (CNT_W=2): push 5 entries with carry=1, popping as needed -> carry_count reads 1,2,3,3,3. Then assert rst mid-stream with level=2 -> level=0, carry_count=0.
